dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port (MemArray port 1: ADDR1/DIN/DOUT1/WE) between two requesters.
- Requester 0 is the CPU load/store path. Requester 1 is a DMA/debug master, used for memory loading and inspection while the core runs.
- CPU has fixed priority, with a starvation limit that forces a DMA grant.
- The block decodes the memory window and returns read data with a one-cycle tag so each requester receives only its own reads.

---
 rtl/dmem_port_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: CPU has fixed priority,
// DMA gets a forced grant after MAXWAIT denials; reads return tagged one cycle later.
module dmem_port_arbiter #(
    parameter int                DBITS   = 16,
    parameter int                ABITS   = 12,
    parameter int                MAXWAIT = 4,
    parameter logic [DBITS-1:0]  BADVAL  = 16'hDEAD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DBITS-1:0]  cpu_addr,
    input  logic [DBITS-1:0]  cpu_din,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DBITS-1:0]  cpu_dout,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [DBITS-1:0]  dma_addr,
    input  logic [DBITS-1:0]  dma_din,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DBITS-1:0]  dma_dout,
    output logic [ABITS-1:0]  mem_addr,
    output logic [DBITS-1:0]  mem_din,
    output logic              mem_we,
    input  logic [DBITS-1:0]  mem_dout,
    output logic              dma_starved
);

    localparam logic [3:0] MAX_WAIT = 4'(MAXWAIT);

    logic [3:0]       waitcnt;
    logic [3:0]       waitcnt_nxt;
    logic             cpu_inwin;
    logic             dma_inwin;
    logic             any_gnt;
    logic             win_we;
    logic             win_inwin;
    logic             tag_valid;
    logic             tag_owner;   // 0 = CPU, 1 = DMA
    logic             tag_inwin;
    logic [DBITS-1:0] rd_data;
    logic [DBITS-1:0] cpu_dout_q;
    logic [DBITS-1:0] dma_dout_q;
    logic             unused_addr_bits;

    // Byte-address bit 0 never selects anything in a word-wide memory.
    assign unused_addr_bits = cpu_addr[0] ^ dma_addr[0];

    assign cpu_inwin = (cpu_addr[DBITS-1:ABITS+1] == '0);
    assign dma_inwin = (dma_addr[DBITS-1:ABITS+1] == '0);

    // Arbitration is purely combinational on the current request.
    assign dma_starved = dma_req && (waitcnt == MAX_WAIT);
    assign cpu_gnt     = cpu_req && !dma_starved;
    assign dma_gnt     = dma_req && !cpu_gnt;
    assign any_gnt     = cpu_gnt || dma_gnt;

    // Without any grant the port idles on the CPU's values.
    assign win_we    = dma_gnt ? dma_we    : cpu_we;
    assign win_inwin = dma_gnt ? dma_inwin : cpu_inwin;
    assign mem_addr  = dma_gnt ? dma_addr[ABITS:1] : cpu_addr[ABITS:1];
    assign mem_din   = dma_gnt ? dma_din : cpu_din;
    assign mem_we    = !rst && any_gnt && win_we && win_inwin;

    always_comb begin
        // NOTE: default first so every path assigns waitcnt_nxt and no latch is inferred.
        waitcnt_nxt = 4'd0;
        if (dma_req && !dma_gnt && (waitcnt != MAX_WAIT))
            waitcnt_nxt = waitcnt + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitcnt   <= 4'd0;
            tag_valid <= 1'b0;
            tag_owner <= 1'b0;
            tag_inwin <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            waitcnt   <= waitcnt_nxt;
            tag_valid <= any_gnt && !win_we;
            tag_owner <= dma_gnt;
            tag_inwin <= win_inwin;
        end
    end

    assign rd_data    = tag_inwin ? mem_dout : BADVAL;
    assign cpu_rvalid = tag_valid && !tag_owner;
    assign dma_rvalid = tag_valid &&  tag_owner;
    assign cpu_dout   = cpu_rvalid ? rd_data : cpu_dout_q;
    assign dma_dout   = dma_rvalid ? rd_data : dma_dout_q;

    // Hold registers keep each requester's last read visible between returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_dout_q <= '0;
            dma_dout_q <= '0;
        end else begin
            cpu_dout_q <= cpu_dout;
            dma_dout_q <= dma_dout;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a stimulus process predicts grants and
// read data from a reference memory; a monitor pops expected returns each cycle.
module tb_dmem_port_arbiter;

    localparam int          MAXWAIT = 4;
    localparam logic [15:0] BADVAL  = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [15:0] cpu_addr = 0, cpu_din = 0, dma_addr = 0, dma_din = 0;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we, dma_starved;
    logic [15:0] cpu_dout, dma_dout, mem_din, mem_dout;
    logic [11:0] mem_addr;

    dmem_port_arbiter #(.DBITS(16), .ABITS(12), .MAXWAIT(MAXWAIT), .BADVAL(BADVAL)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_dout(cpu_dout),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_dout(dma_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .dma_starved(dma_starved)
    );

    always #5 clk = ~clk;

    // Physical memory array driven by the DUT: registered read, one-cycle latency.
    logic [15:0] phys_mem [4096];
    always @(posedge clk) begin
        if (mem_we) phys_mem[mem_addr] <= mem_din;
        mem_dout <= phys_mem[mem_addr];
    end

    // Reference model state.
    logic [15:0] ref_mem [4096];
    int          denied;

    typedef struct {
        logic [15:0] data;
        int          due;
    } rd_t;
    rd_t cpu_q[$];
    rd_t dma_q[$];

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] last_cpu = 0, last_dma = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic in_window(input logic [15:0] a);
        return a[15:13] == 3'b000;
    endfunction

    function automatic logic [15:0] gen_addr();
        logic [15:0] a;
        if ($urandom_range(0, 9) == 0) begin
            a = 16'($urandom);
            if (a[15:13] == 3'b000) a[15] = 1'b1;
        end else begin
            a = (16'($urandom_range(0, 31)) << 1) | 16'($urandom_range(0, 1));
        end
        return a;
    endfunction

    // One request cycle: drive at negedge, predict from spec rules, check, enqueue reads.
    task automatic drive_cycle(input logic c_req, input logic c_we,
                               input logic [15:0] c_addr, input logic [15:0] c_din,
                               input logic d_req, input logic d_we,
                               input logic [15:0] d_addr, input logic [15:0] d_din,
                               output logic c_g, output logic d_g);
        logic        starved, w_we;
        logic [15:0] w_addr, w_din, rdat;
        @(negedge clk);
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_din = c_din;
        dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_din = d_din;
        #1;
        starved = d_req && (denied == MAXWAIT);
        c_g     = c_req && !starved;
        d_g     = d_req && !c_g;
        w_we    = d_g ? d_we   : c_we;
        w_addr  = d_g ? d_addr : c_addr;
        w_din   = d_g ? d_din  : c_din;
        check("cpu_gnt", 32'(cpu_gnt), 32'(c_g));
        check("dma_gnt", 32'(dma_gnt), 32'(d_g));
        check("dma_starved", 32'(dma_starved), 32'(starved));
        check("mem_we", 32'(mem_we), 32'((c_g || d_g) && w_we && in_window(w_addr)));
        check("mem_addr", 32'(mem_addr), 32'(w_addr[12:1]));
        check("mem_din", 32'(mem_din), 32'(w_din));
        if ((c_g || d_g) && !w_we) begin
            rdat = in_window(w_addr) ? ref_mem[w_addr[12:1]] : BADVAL;
            if (d_g) dma_q.push_back('{data: rdat, due: cyc + 1});
            else     cpu_q.push_back('{data: rdat, due: cyc + 1});
        end
        if ((c_g || d_g) && w_we && in_window(w_addr))
            ref_mem[w_addr[12:1]] = w_din;
        if (d_req && !d_g) denied = (denied < MAXWAIT) ? denied + 1 : MAXWAIT;
        else               denied = 0;
    endtask

    task automatic mon_one(input string nm, input logic rv, input logic [15:0] dout,
                           input logic have, input logic [15:0] exp,
                           inout logic [15:0] last);
        check({nm, "_rvalid"}, 32'(rv), 32'(have));
        if (have) begin
            check({nm, "_dout"}, 32'(dout), 32'(exp));
            last = exp;
        end else begin
            check({nm, "_dout_hold"}, 32'(dout), 32'(last));
        end
    endtask

    // Monitor: every cycle compares each return channel against the scoreboard.
    initial begin
        logic        have;
        logic [15:0] exp;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            have = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
            exp  = have ? cpu_q[0].data : 16'h0;
            if (have) void'(cpu_q.pop_front());
            mon_one("cpu", cpu_rvalid, cpu_dout, have, exp, last_cpu);
            have = (dma_q.size() > 0) && (dma_q[0].due == cyc);
            exp  = have ? dma_q[0].data : 16'h0;
            if (have) void'(dma_q.pop_front());
            mon_one("dma", dma_rvalid, dma_dout, have, exp, last_dma);
        end
    end

    task automatic check_reset_outputs();
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        check("rst_dma_dout", 32'(dma_dout), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
    endtask

    task automatic idle(input int n);
        logic cg, dg;
        for (int i = 0; i < n; i++)
            drive_cycle(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, cg, dg);
    endtask

    initial begin
        logic        cg, dg, c_pend, d_pend;
        logic        c_req, c_we, d_req, d_we;
        logic [15:0] c_addr, c_din, d_addr, d_din;

        for (int i = 0; i < 4096; i++) begin
            phys_mem[i] = 16'($urandom);
            ref_mem[i]  = phys_mem[i];
        end
        denied = 0;

        // Reset state, with a CPU write pending to prove MEM_WE is blocked.
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_din = 16'h5555;
        #12;
        check_reset_outputs();
        @(negedge clk);
        check_reset_outputs();
        cpu_req = 0; cpu_we = 0;
        @(posedge clk);
        #2 rst = 1'b0;

        // Reset arriving while a DMA read is in flight discards the return.
        drive_cycle(0, 0, 16'h0, 16'h0, 1, 0, 16'h0010, 16'h0, cg, dg);
        #1;
        rst = 1'b1;
        cpu_q.delete(); dma_q.delete();
        last_cpu = 0; last_dma = 0; denied = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_din = 16'h7777;
        #1 check_reset_outputs();
        @(posedge clk);
        #2 check_reset_outputs();
        cpu_req = 0; cpu_we = 0; dma_req = 0;
        rst = 1'b0;

        // Write then read back through the CPU.
        drive_cycle(1, 1, 16'h0040, 16'h1234, 0, 0, 16'h0, 16'h0, cg, dg);
        drive_cycle(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0, cg, dg);

        // Out-of-window read returns BADVAL; out-of-window write is granted but dropped.
        drive_cycle(1, 0, 16'hFFF2, 16'h0, 0, 0, 16'h0, 16'h0, cg, dg);
        drive_cycle(1, 1, 16'hFFFC, 16'hAAAA, 0, 0, 16'h0, 16'h0, cg, dg);

        // Starvation: both held high; DMA forced on the (MAXWAIT+1)th cycle.
        for (int i = 0; i < MAXWAIT + 3; i++)
            drive_cycle(1, 0, 16'h0006, 16'h0, 1, 0, 16'h000A, 16'h0, cg, dg);
        idle(1);

        // Interleaved reads on alternate cycles.
        drive_cycle(1, 0, 16'h0002, 16'h0, 0, 0, 16'h0, 16'h0, cg, dg);
        drive_cycle(0, 0, 16'h0, 16'h0, 1, 0, 16'h0004, 16'h0, cg, dg);
        idle(1);

        // Simultaneous CPU read and DMA write; DMA write lands next cycle, then read back.
        drive_cycle(1, 0, 16'h0020, 16'h0, 1, 1, 16'h0008, 16'hBEEF, cg, dg);
        drive_cycle(0, 0, 16'h0, 16'h0, 1, 1, 16'h0008, 16'hBEEF, cg, dg);
        drive_cycle(0, 0, 16'h0, 16'h0, 1, 0, 16'h0008, 16'h0, cg, dg);
        idle(2);

        // Random traffic; an ungranted request is held stable until granted.
        c_pend = 0; d_pend = 0;
        c_req = 0; c_we = 0; c_addr = 0; c_din = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_din = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!c_pend) begin
                c_req  = ($urandom_range(0, 99) < 60);
                c_we   = ($urandom_range(0, 2) == 0);
                c_addr = gen_addr();
                c_din  = 16'($urandom);
            end
            if (!d_pend) begin
                d_req  = ($urandom_range(0, 99) < 55);
                d_we   = ($urandom_range(0, 2) == 0);
                d_addr = gen_addr();
                d_din  = 16'($urandom);
            end
            drive_cycle(c_req, c_we, c_addr, c_din, d_req, d_we, d_addr, d_din, cg, dg);
            c_pend = c_req && !cg;
            d_pend = d_req && !dg;
        end
        idle(3);

        check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        check("dma_q_drained", 32'(dma_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
